// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage and data memory.
// Single outstanding request: req/gnt handshake, then one rvalid per grant.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: byte/half/word loads and stores over a
// single-outstanding bus, registered result to writeback. Load data is
// returned lane-shifted to bit 0; extension happens in writeback.
module mem_access #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_is_mem,
  input  logic [3:0]          in_op_spec,
  input  logic [31:0]         in_addr,
  input  logic [31:0]         in_st_dat,
  input  logic [31:0]         in_reg_dat,
  input  logic                flush,
  mem_access_if.master        bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_mem_dat,
  output logic [31:0]         out_reg_dat,
  output logic [3:0]          out_op_spec,
  output logic                out_is_mem,
  output logic                out_fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } state_t;

  state_t               state;
  logic [1:0]           addr_lo;
  logic [TIMEOUT_W-1:0] wdog;
  logic [TIMEOUT_W-1:0] wdog_inc;
  logic                 wdog_fire;
  logic                 out_stall;
  logic                 capture;
  logic                 misaligned;
  logic                 is_store_in;
  logic [3:0]           be_in;
  logic [31:0]          wdata_in;
  logic [31:0]          resp_dat;

  assign out_stall   = out_valid && !out_ready;
  assign in_ready    = (state == IDLE) && !out_stall;
  // A flush in the same cycle wins over a new capture.
  assign capture     = in_valid && in_ready && !flush;
  assign is_store_in = (in_op_spec >= 4'd5) && (in_op_spec <= 4'd7);
  assign wdata_in    = in_st_dat << {in_addr[1:0], 3'b000};
  assign resp_dat    = bus.dmem_we ? '0 : (bus.dmem_rdata >> {addr_lo, 3'b000});

  // The counter holds cycles already completed in the current state, so the
  // fire test looks at the incremented value: the 2^W-1'th waiting cycle ends
  // the wait.
  assign wdog_inc  = wdog + 1'b1;
  assign wdog_fire = (wdog_inc == '1);

  // Access-size decode: byte enables and alignment check for the incoming op.
  always_comb begin
    misaligned = 1'b0;
    be_in      = 4'b1111;
    case (in_op_spec)
      4'd0, 4'd3, 4'd5: be_in = 4'b0001 << in_addr[1:0];
      4'd1, 4'd4, 4'd6: begin
        be_in      = 4'b0011 << in_addr[1:0];
        misaligned = in_addr[0];
      end
      default:          misaligned = (in_addr[1:0] != 2'b00);
    endcase
  end

  // Stage FSM with registered bus request and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      out_fault      <= 1'b0;
      out_mem_dat    <= '0;
      out_reg_dat    <= '0;
      out_op_spec    <= '0;
      out_is_mem     <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_be    <= '0;
      bus.dmem_wdata <= '0;
      addr_lo        <= '0;
      wdog           <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (capture) begin
            out_reg_dat <= in_reg_dat;
            out_op_spec <= in_op_spec;
            out_is_mem  <= in_is_mem;
            out_mem_dat <= '0;
            out_fault   <= 1'b0;
            if (!in_is_mem) begin
              out_valid <= 1'b1;
            end else if (misaligned) begin
              out_valid <= 1'b1;
              out_fault <= 1'b1;
            end else begin
              // Output regs are free here (no stall), so they double as the
              // holding latches for the passthrough fields of the access.
              out_valid      <= 1'b0;
              state          <= REQ;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= is_store_in;
              bus.dmem_addr  <= {in_addr[31:2], 2'b00};
              bus.dmem_be    <= be_in;
              bus.dmem_wdata <= wdata_in;
              addr_lo        <= in_addr[1:0];
            end
          end else if (flush || (out_valid && out_ready)) begin
            out_valid <= 1'b0;
          end
        end

        REQ: begin
          if (flush) begin
            bus.dmem_req <= 1'b0;
            wdog         <= '0;
            // A response arriving together with the grant is already consumed.
            state        <= (bus.dmem_gnt && !bus.dmem_rvalid) ? DRAIN : IDLE;
          end else if (bus.dmem_gnt) begin
            bus.dmem_req <= 1'b0;
            wdog         <= '0;
            if (bus.dmem_rvalid) begin
              state       <= HOLD;
              out_valid   <= 1'b1;
              out_mem_dat <= resp_dat;
            end else begin
              state <= WAIT;
            end
          end else if (wdog_fire) begin
            bus.dmem_req <= 1'b0;
            wdog         <= '0;
            state        <= HOLD;
            out_valid    <= 1'b1;
            out_fault    <= 1'b1;
            out_mem_dat  <= '0;
          end else begin
            wdog <= wdog_inc;
          end
        end

        WAIT: begin
          if (flush) begin
            wdog  <= '0;
            state <= bus.dmem_rvalid ? IDLE : DRAIN;
          end else if (bus.dmem_rvalid) begin
            wdog        <= '0;
            state       <= HOLD;
            out_valid   <= 1'b1;
            out_mem_dat <= resp_dat;
          end else if (wdog_fire) begin
            wdog        <= '0;
            state       <= HOLD;
            out_valid   <= 1'b1;
            out_fault   <= 1'b1;
            out_mem_dat <= '0;
          end else begin
            wdog <= wdog_inc;
          end
        end

        DRAIN: begin
          if (bus.dmem_rvalid || wdog_fire) begin
            wdog  <= '0;
            state <= IDLE;
          end else begin
            wdog <= wdog_inc;
          end
        end

        HOLD: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
